// File: rtl/gpio_bank_pkg.sv
// gpio_bank_pkg: shared constants for the GPIO bank.
//   - Register addresses REG_DIR..REG_OUT_CLR (3-bit bus address).
//   - REG_DATA_W: register bus data width.
//   - MAX_PINS: largest supported pin count (one bus word).
package gpio_bank_pkg;

  localparam int REG_DATA_W = 32;
  localparam int MAX_PINS   = REG_DATA_W;

  localparam logic [2:0] REG_DIR      = 3'd0;
  localparam logic [2:0] REG_OUT      = 3'd1;
  localparam logic [2:0] REG_IN       = 3'd2;
  localparam logic [2:0] REG_RISE_EN  = 3'd3;
  localparam logic [2:0] REG_FALL_EN  = 3'd4;
  localparam logic [2:0] REG_IRQ_STAT = 3'd5;
  localparam logic [2:0] REG_OUT_SET  = 3'd6;
  localparam logic [2:0] REG_OUT_CLR  = 3'd7;

endpackage

// File: rtl/gpio_sync_edge.sv
// gpio_sync_edge: per-pin input synchroniser with edge detection.
//   clk, rst_n  : clock, asynchronous active-low reset
//   pin_async   : raw pin levels, asynchronous to clk
//   sync        : synchronised level (after SYNC_STAGES flops)
//   rise, fall  : single-cycle edge flags derived from sync vs. its previous sample
module gpio_sync_edge
  import gpio_bank_pkg::*;
#(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_PINS-1:0] pin_async,
  output logic [NUM_PINS-1:0] sync,
  output logic [NUM_PINS-1:0] rise,
  output logic [NUM_PINS-1:0] fall
);

  logic [NUM_PINS-1:0] stage_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
      prev_q <= '0;
    end else begin
      stage_q[0] <= pin_async;
      for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
      prev_q <= stage_q[SYNC_STAGES-1];
    end
  end

  assign sync = stage_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/gpio_bank.sv
// gpio_bank: multi-pin GPIO controller with edge interrupts.
//   clk, rst_n           : clock, asynchronous active-low reset
//   reg_addr/wr/wdata    : register write port (reg_wr is a one-cycle strobe)
//   reg_rd               : read strobe; reg_rdata/reg_rvalid answer one cycle later
//   gpio_in              : pin levels from the IO cells (asynchronous)
//   gpio_out, gpio_oe    : output data and output enable to the IO cells (flop outputs)
//   irq                  : high while any IRQ_STAT bit is set
//
// Bus handshake: there is no back-pressure. Every reg_wr strobe is accepted on
// the edge it is sampled; every reg_rd strobe sampled on edge n produces
// reg_rvalid=1 for exactly the cycle after edge n, with reg_rdata held until
// the next read. Reads sample register state before any same-cycle write.
module gpio_bank
  import gpio_bank_pkg::*;
#(
  parameter int                  NUM_PINS    = 8,
  parameter int                  SYNC_STAGES = 2,
  parameter logic [NUM_PINS-1:0] DIR_RESET   = '0,
  parameter logic [NUM_PINS-1:0] OUT_RESET   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [2:0]            reg_addr,
  input  logic                  reg_wr,
  input  logic [REG_DATA_W-1:0] reg_wdata,
  input  logic                  reg_rd,
  output logic [REG_DATA_W-1:0] reg_rdata,
  output logic                  reg_rvalid,
  input  logic [NUM_PINS-1:0]   gpio_in,
  output logic [NUM_PINS-1:0]   gpio_out,
  output logic [NUM_PINS-1:0]   gpio_oe,
  output logic                  irq
);

  logic [NUM_PINS-1:0]   dir_q, out_q, rise_en_q, fall_en_q, irq_stat_q;
  logic [NUM_PINS-1:0]   in_sync, in_rise, in_fall;
  logic [NUM_PINS-1:0]   wr_data, w1c_mask, set_mask;
  logic [REG_DATA_W-1:0] rd_mux;
  logic [REG_DATA_W-1:0] rdata_q;
  logic                  rvalid_q;

  assign wr_data = reg_wdata[NUM_PINS-1:0];

  // Write-data bits above the pin count have no register behind them.
  if (NUM_PINS < REG_DATA_W) begin : g_wdata_hi
    logic unused_wdata_hi;
    assign unused_wdata_hi = |reg_wdata[REG_DATA_W-1:NUM_PINS];
  end

  gpio_sync_edge #(
    .NUM_PINS   (NUM_PINS),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .pin_async(gpio_in),
    .sync     (in_sync),
    .rise     (in_rise),
    .fall     (in_fall)
  );

  // Control registers. OUT_SET/OUT_CLR are read-modify-write on out_q;
  // only one address is written per cycle so they never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q     <= DIR_RESET;
      out_q     <= OUT_RESET;
      rise_en_q <= '0;
      fall_en_q <= '0;
    end else if (reg_wr) begin
      case (reg_addr)
        REG_DIR:     dir_q     <= wr_data;
        REG_OUT:     out_q     <= wr_data;
        REG_RISE_EN: rise_en_q <= wr_data;
        REG_FALL_EN: fall_en_q <= wr_data;
        REG_OUT_SET: out_q     <= out_q | wr_data;
        REG_OUT_CLR: out_q     <= out_q & ~wr_data;
        default: ;
      endcase
    end
  end

  // Sticky status: new edges are OR-ed in after the clear so a same-cycle
  // set beats write-1-to-clear.
  assign w1c_mask = (reg_wr && reg_addr == REG_IRQ_STAT) ? wr_data : '0;
  assign set_mask = (in_rise & rise_en_q) | (in_fall & fall_en_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq_stat_q <= '0;
    else        irq_stat_q <= (irq_stat_q & ~w1c_mask) | set_mask;
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      REG_DIR:      rd_mux[NUM_PINS-1:0] = dir_q;
      REG_OUT:      rd_mux[NUM_PINS-1:0] = out_q;
      REG_IN:       rd_mux[NUM_PINS-1:0] = in_sync;
      REG_RISE_EN:  rd_mux[NUM_PINS-1:0] = rise_en_q;
      REG_FALL_EN:  rd_mux[NUM_PINS-1:0] = fall_en_q;
      REG_IRQ_STAT: rd_mux[NUM_PINS-1:0] = irq_stat_q;
      default:      rd_mux = '0; // OUT_SET / OUT_CLR are write-only
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= reg_rd;
      if (reg_rd) rdata_q <= rd_mux;
    end
  end

  assign reg_rdata  = rdata_q;
  assign reg_rvalid = rvalid_q;
  assign gpio_oe    = dir_q;
  assign gpio_out   = out_q;
  assign irq        = |irq_stat_q;

endmodule
